// File: rtl/movsum_pkg.sv
// Shared constants, state encoding and sign-extension helper
// for the 21-sample moving-sum block.
package movsum_pkg;

  localparam int WIN   = 21;
  localparam int W_IN  = 32;
  localparam int W_ACC = 37;
  localparam int W_CNT = 5;

  localparam logic [W_CNT-1:0] CNT_FULL = W_CNT'(WIN);
  localparam logic [W_CNT-1:0] CNT_LAST = W_CNT'(WIN - 1);

  localparam logic [W_IN-1:0] SAT_MAX = 32'h7FFF_FFFF;
  localparam logic [W_IN-1:0] SAT_MIN = 32'h8000_0000;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_t;

  function automatic logic [W_ACC-1:0] sext(
    input logic [W_IN-1:0] x
  );
    return {{(W_ACC-W_IN){x[W_IN-1]}}, x};
  endfunction

endpackage

// File: rtl/sat_s37_to_s32.sv
// Signed 37-to-32 bit range check; clamps when MOVSUM_SAT_EN
// is defined, otherwise truncates (wraps).
module sat_s37_to_s32
  import movsum_pkg::*;
(
  input  logic [W_ACC-1:0] a,
  output logic [W_IN-1:0]  y,
  output logic             ovf
);

  // In range iff every bit above bit 31 copies bit 31.
  logic [W_ACC-W_IN:0] hi;

  assign hi  = a[W_ACC-1:W_IN-1];
  assign ovf = (hi != {(W_ACC-W_IN+1){a[W_IN-1]}});

`ifdef MOVSUM_SAT_EN
  assign y = !ovf      ? a[W_IN-1:0] :
             a[W_ACC-1] ? SAT_MIN    :
                          SAT_MAX;
`else
  assign y = a[W_IN-1:0];
`endif

endmodule

// File: rtl/moving_sum_w21.sv
// Running sum of the last 21 signed samples with warm-up,
// clear and overflow flag; define MOVSUM_SAT_EN to clamp out.
module moving_sum_w21
  import movsum_pkg::*;
(
  input  logic            clk,
  input  logic            GlobalReset,
  input  logic [W_IN-1:0] in,
  input  logic [W_IN-1:0] in_d21,
  input  logic            clear,
  output logic [W_IN-1:0] out,
  output logic            out_valid,
  output logic            ovf
);

  state_t             state;
  state_t             state_nx;
  logic [W_ACC-1:0]   acc;
  logic [W_ACC-1:0]   acc_nx;
  logic [W_CNT-1:0]   cnt;
  logic [W_CNT-1:0]   cnt_nx;
  logic [W_IN-1:0]    sat_y;
  logic               sat_ovf;

  always_ff @(posedge clk or posedge GlobalReset) begin
    if (GlobalReset) begin
      state <= FILL;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (1'b1)
      clear: state_nx = FILL;
      (!clear && state == FILL && cnt == CNT_LAST):
        state_nx = FULL;
      default: ;
    endcase
  end

  // During fill, in_d21 still carries pre-clear data.
  always_comb begin
    acc_nx = acc;
    cnt_nx = cnt;
    if (clear) begin
      acc_nx = '0;
      cnt_nx = '0;
    end else begin
      unique case (state)
        FILL: begin
          acc_nx = acc + sext(in);
          cnt_nx = cnt + 1'b1;
        end
        FULL: begin
          acc_nx = acc + sext(in) - sext(in_d21);
        end
        default: ;
      endcase
    end
  end

  sat_s37_to_s32 u_sat (
    .a   (acc_nx),
    .y   (sat_y),
    .ovf (sat_ovf)
  );

  always_ff @(posedge clk or posedge GlobalReset) begin
    if (GlobalReset) begin
      acc       <= '0;
      cnt       <= '0;
      out       <= '0;
      out_valid <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      acc       <= acc_nx;
      cnt       <= cnt_nx;
      out       <= sat_y;
      out_valid <= (cnt_nx == CNT_FULL);
      ovf       <= sat_ovf;
    end
  end

endmodule

// File: tb/tb_moving_sum_w21.sv
// Directed bench for moving_sum_w21 with a local 21-deep
// delay line feeding in_d21.
module tb_moving_sum_w21;

  logic        clk = 1'b0;
  logic        GlobalReset = 1'b1;
  logic [31:0] din = '0;
  logic [31:0] din_d21;
  logic        clear = 1'b0;
  logic [31:0] out;
  logic        out_valid;
  logic        ovf;

  logic [31:0] dl [21];

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  always_ff @(posedge clk or posedge GlobalReset) begin
    if (GlobalReset) begin
      for (int i = 0; i < 21; i++) dl[i] <= '0;
    end else begin
      dl[0] <= din;
      for (int i = 1; i < 21; i++) dl[i] <= dl[i-1];
    end
  end

  assign din_d21 = dl[20];

  moving_sum_w21 dut (
    .clk         (clk),
    .GlobalReset (GlobalReset),
    .in          (din),
    .in_d21      (din_d21),
    .clear       (clear),
    .out         (out),
    .out_valid   (out_valid),
    .ovf         (ovf)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input logic [31:0] s, input logic c);
    din   = s;
    clear = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] v;

    // reset state, before any clock edge releases it
    #2;
    chk("rst_out", out, 32'd0);
    chk("rst_vld", {31'd0, out_valid}, 32'd0);
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
    @(posedge clk);
    #1;
    GlobalReset = 1'b0;

    // ramp with in=1
    for (int i = 1; i <= 21; i++) begin
      step(32'd1, 1'b0);
      chk("ramp_out", out, 32'(i));
      chk("ramp_vld", {31'd0, out_valid}, {31'd0, i == 21});
    end
    for (int i = 0; i < 5; i++) begin
      step(32'd1, 1'b0);
      chk("hold_out", out, 32'd21);
      chk("hold_vld", {31'd0, out_valid}, 32'd1);
    end

    // flush to zeros, then single impulse
    for (int i = 0; i < 21; i++) step(32'd0, 1'b0);
    chk("flush_out", out, 32'd0);
    step(32'd100, 1'b0);
    chk("imp_out", out, 32'd100);
    for (int i = 0; i < 20; i++) begin
      step(32'd0, 1'b0);
      chk("imp_hold", out, 32'd100);
      chk("imp_vld", {31'd0, out_valid}, 32'd1);
    end
    step(32'd0, 1'b0);
    chk("imp_end", out, 32'd0);
    chk("imp_end_vld", {31'd0, out_valid}, 32'd1);

    // fill with 5s, clear, refill
    for (int i = 1; i <= 21; i++) step(32'd5, 1'b0);
    chk("five_full", out, 32'd105);
    step(32'd5, 1'b1);
    chk("clr_out", out, 32'd0);
    chk("clr_vld", {31'd0, out_valid}, 32'd0);
    for (int i = 1; i <= 21; i++) begin
      step(32'd5, 1'b0);
      chk("refill_out", out, 32'(5 * i));
      chk("refill_vld", {31'd0, out_valid}, {31'd0, i == 21});
    end
    // drain: each post-clear 5 expires exactly 21 samples later
    for (int i = 1; i <= 21; i++) begin
      step(32'd0, 1'b0);
      chk("drain_out", out, 32'(105 - 5 * i));
    end

    // alternating +7/-7
    for (int j = 0; j < 32; j++) begin
      v = (j % 2 == 0) ? 32'd7 : -32'd7;
      step(v, 1'b0);
      if (j >= 20) chk("alt_out", out, v);
      else chk("alt_fill", out, (j % 2 == 0) ? 32'd7 : 32'd0);
      chk("alt_ovf", {31'd0, ovf}, 32'd0);
    end

    // positive overflow
    step(32'd0, 1'b1);
    step(32'h7FFF_FFFF, 1'b0);
    chk("pmax1_out", out, 32'h7FFF_FFFF);
    chk("pmax1_ovf", {31'd0, ovf}, 32'd0);
    step(32'h7FFF_FFFF, 1'b0);
    chk("pmax2_ovf", {31'd0, ovf}, 32'd1);
`ifdef MOVSUM_SAT_EN
    chk("pmax2_out", out, 32'h7FFF_FFFF);
`else
    chk("pmax2_out", out, 32'hFFFF_FFFE);
`endif

    // negative overflow; ovf must drop on clear
    step(32'd0, 1'b1);
    chk("ovf_clr", {31'd0, ovf}, 32'd0);
    step(32'h8000_0000, 1'b0);
    chk("nmin1_out", out, 32'h8000_0000);
    chk("nmin1_ovf", {31'd0, ovf}, 32'd0);
    step(32'h8000_0000, 1'b0);
    chk("nmin2_ovf", {31'd0, ovf}, 32'd1);
`ifdef MOVSUM_SAT_EN
    chk("nmin2_out", out, 32'h8000_0000);
`else
    chk("nmin2_out", out, 32'h0000_0000);
`endif

    // reset mid-FULL, asynchronous
    step(32'd0, 1'b1);
    for (int i = 0; i < 23; i++) step(32'd3, 1'b0);
    chk("pre_rst_out", out, 32'd63);
    chk("pre_rst_vld", {31'd0, out_valid}, 32'd1);
    #2;
    GlobalReset = 1'b1;
    #1;
    chk("arst_out", out, 32'd0);
    chk("arst_vld", {31'd0, out_valid}, 32'd0);
    chk("arst_ovf", {31'd0, ovf}, 32'd0);
    @(posedge clk);
    #1;
    GlobalReset = 1'b0;
    for (int i = 1; i <= 21; i++) begin
      step(32'd2, 1'b0);
      chk("rfl_out", out, 32'(2 * i));
      chk("rfl_vld", {31'd0, out_valid}, {31'd0, i == 21});
    end
    step(32'd2, 1'b0);
    chk("rfl_hold", out, 32'd42);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
